avmm_mult_responder: RTL and testbench
======================================

// Module: avmm_mult_responder
// PURPOSE
//  Avalon-MM responder on the HPS lightweight bridge: the HPS writes two operands,
//  kicks a start bit, and polls or takes an IRQ for the result.
//  Contains an iterative unsigned shift-add multiplier as the arithmetic unit under test.
//  Sits in the FPGA fabric beside the PIOs, on clk_clk.
// PARAMETERS
//  WIDTH    32           operand width; product is 2*WIDTH bits (max 32)
//  ID_VALUE 32'h4D554C54 constant returned at word address 7
// PORTS
//  clk            in   1   system clock (clk_clk domain)
//  reset          in   1   synchronous, active-high reset
//  avs_address    in   3   word address
//  avs_read       in   1   read strobe, single cycle
//  avs_write      in   1   write strobe, single cycle
//  avs_writedata  in   32  write data
//  avs_readdata   out  32  read data, registered
//  avs_readdatavalid out 1 high exactly one cycle after an accepted read
//  irq            out  1   level interrupt: done & irq_en
// BEHAVIOUR
//  Interface
//  - One clock; reset is synchronous and active-high.
//  - No waitrequest: every access is accepted in its strobe cycle.
//  - Read latency is fixed at 1 cycle.
//  - read and write asserted together: the write takes effect and the read returns pre-write data.
//  Register map (word addresses)
//  - 0 OPA RW, 1 OPB RW: zero-extended to 32 bits; upper bits are ignored on write.
//  - 2 CTRL:
//    - bit0 START: write-1 pulse, reads 0.
//    - bit1 IRQ_EN: RW.
//  - 3 STATUS:
//    - bit0 BUSY: RO.
//    - bit1 DONE: sticky; write-1 clears it.
//  - 4 RES_LO: product[31:0]. 5 RES_HI: product[2W-1:32], zero-padded.
//  - 6 CYCLES: count of busy cycles of the last operation. 7 ID = ID_VALUE.
//  - Unused or read-only bits read 0; writes to read-only registers are ignored.
//  Reset values
//  - All registers, outputs, busy, done and irq are 0.
//  - avs_readdatavalid is 0.
//  FSM: IDLE -> RUN -> IDLE
//  - IDLE, START=1 written at cycle T:
//    - Latch OPA/OPB into working regs; clear accumulator, DONE and CYCLES.
//    - BUSY=1 from cycle T+1.
//  - RUN, each cycle:
//    - If multiplier LSB=1: acc += multiplicand.
//    - Shift multiplicand left and multiplier right; bit counter +1; CYCLES +1.
//  - After exactly WIDTH RUN cycles:
//    - Product is written to RES_LO/HI, BUSY=0, DONE=1; DONE is visible at T+1+WIDTH.
//    - Return to IDLE.
//  - Fixed latency: no early exit when the multiplier reaches 0.
//  - RES_LO/HI hold the previous product until the new one completes.
//  Boundary conditions
//  - START while BUSY: ignored; the running operation and IRQ_EN are unaffected.
//  - OPA/OPB writes while BUSY: update the registers only; the running operation uses latched values.
//  - DONE clear and completion in the same cycle: completion wins, DONE=1.
//  - START written together with IRQ_EN in one write: both take effect.
//  - Reset mid-operation: immediate IDLE, all state zero, no DONE, irq=0.
//  - Arithmetic: unsigned, full 2*WIDTH product, no overflow possible; CYCLES saturates at 2^32-1.
// TESTING
//  1. OPA=3, OPB=5, START, poll STATUS -> DONE at T+1+32; RES_LO=15, RES_HI=0, CYCLES=32.
//  2. OPA=OPB=32'hFFFFFFFF -> RES_HI=32'hFFFFFFFE, RES_LO=32'h00000001.
//  3. 7*9 running, START again with OPA=2 at T+4 -> ignored; result 63, CYCLES=32.
//  4. IRQ_EN=1, 6*7 -> irq rises with DONE; write STATUS=2 -> irq=0 next cycle; RES_LO=42.
//  5. reset asserted at T+10 of 100*100 -> BUSY=0, DONE=0, RES_LO=0, irq=0 after reset.
//  6. Read address 7 -> avs_readdatavalid exactly 1 cycle later, data 32'h4D554C54;
//     back-to-back reads return in order.

Source files
------------

// File: rtl/avmm_mult_responder.sv
// Avalon-MM responder wrapping an iterative unsigned shift-add multiplier.
// The host loads OPA/OPB, pulses START, then polls STATUS or waits for irq.
module avmm_mult_responder #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [31:0] ID_VALUE = 32'h4D554C54
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        irq
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     mcand_q, mcand_d, acc_q, acc_d, res_q, res_d;
  logic [PW-1:0]     acc_next;
  logic [5:0]        bitcnt_q, bitcnt_d;
  logic [31:0]       cycles_q, cycles_d;
  logic              irq_en_q, irq_en_d, done_q, done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic [63:0]       res_ext;

  assign res_ext           = 64'(res_q);
  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign irq               = done_q & irq_en_q;

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    res_d    = res_q;
    bitcnt_d = bitcnt_q;
    cycles_d = cycles_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    rdata_d  = rdata_q;
    rvalid_d = avs_read;
    acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    if (avs_write) begin
      case (avs_address)
        3'd0: opa_d = avs_writedata[WIDTH-1:0];
        3'd1: opb_d = avs_writedata[WIDTH-1:0];
        // A START issued while busy is dropped as a whole, IRQ_EN included.
        3'd2: if (!(state_q == S_RUN && avs_writedata[0])) irq_en_d = avs_writedata[1];
        3'd3: if (avs_writedata[1]) done_d = 1'b0;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (avs_write && avs_address == 3'd2 && avs_writedata[0]) begin
          state_d  = S_RUN;
          mcand_d  = PW'(opa_q);
          mplier_d = opb_q;
          acc_d    = '0;
          bitcnt_d = '0;
          cycles_d = '0;
          done_d   = 1'b0;
        end
      end
      S_RUN: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        bitcnt_d = bitcnt_q + 6'd1;
        if (cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
        // Completion overrides a same-cycle DONE clear from the host.
        if (bitcnt_q == 6'(WIDTH - 1)) begin
          res_d   = acc_next;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (avs_read) begin
      case (avs_address)
        3'd0: rdata_d = 32'(opa_q);
        3'd1: rdata_d = 32'(opb_q);
        3'd2: rdata_d = {30'd0, irq_en_q, 1'b0};
        3'd3: rdata_d = {30'd0, done_q, (state_q == S_RUN)};
        3'd4: rdata_d = res_ext[31:0];
        3'd5: rdata_d = res_ext[63:32];
        3'd6: rdata_d = cycles_q;
        3'd7: rdata_d = ID_VALUE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      bitcnt_q <= '0;
      cycles_q <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      bitcnt_q <= bitcnt_d;
      cycles_q <= cycles_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_avmm_mult_responder.sv
// Bench for avmm_mult_responder: reset map, vector table, random products
// against a plain-arithmetic model, and hand-written timing corner cases.
module tb_avmm_mult_responder;

  localparam int W = 32;
  localparam logic [31:0] ID = 32'h4D554C54;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic        avs_readdatavalid, irq;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  avmm_mult_responder #(.WIDTH(W), .ID_VALUE(ID)) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .irq(irq)
  );

  typedef struct { logic [31:0] a; logic [31:0] b; logic [63:0] p; } vec_t;
  typedef struct { logic [2:0] addr; logic [31:0] exp; } rdv_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(posedge clk); #1 avs_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(posedge clk); #1 avs_read = 1'b0;
    @(negedge clk);
    d = avs_readdata;
    check("readdatavalid", 32'(avs_readdatavalid), 32'd1);
  endtask

  // Polls STATUS; k = index of the first poll that sees DONE (poll 0 samples T+1).
  task automatic wait_done(output int k, output logic [31:0] first_status);
    logic [31:0] s;
    k = 0;
    forever begin
      rd(3'd3, s);
      if (k == 0) first_status = s;
      if (s[1]) break;
      k++;
      if (k > 200) begin
        check("done_timeout", 32'(k), 32'(W));
        break;
      end
    end
  endtask

  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input string tag,
                          input logic [63:0] p);
    int k; logic [31:0] s0, lo, hi, cyc;
    wr(3'd0, a); wr(3'd1, b); wr(3'd2, 32'd1);
    wait_done(k, s0);
    check({tag, "_busy_t1"}, s0, 32'd1);
    check({tag, "_done_lat"}, 32'(k), 32'(W));
    rd(3'd4, lo); rd(3'd5, hi); rd(3'd6, cyc);
    check({tag, "_lo"}, lo, p[31:0]);
    check({tag, "_hi"}, hi, p[63:32]);
    check({tag, "_cycles"}, cyc, 32'(W));
  endtask

  initial begin
    vec_t tbl[6];
    rdv_t rst_tbl[8];
    logic [31:0] d, a, b;
    int k;

    tbl[0] = '{32'd3, 32'd5, 64'd15};
    tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    tbl[2] = '{32'd0, 32'hDEAD_BEEF, 64'd0};
    tbl[3] = '{32'd1, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
    tbl[4] = '{32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000};
    tbl[5] = '{32'h1234_5678, 32'h10, 64'h0000_0001_2345_6780};
    for (int i = 0; i < 7; i++) rst_tbl[i] = '{3'(i), 32'd0};
    rst_tbl[7] = '{3'd7, ID};

    reset = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_rvalid", 32'(avs_readdatavalid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", avs_readdata, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd(rst_tbl[i].addr, d);
      check($sformatf("rst_reg%0d", rst_tbl[i].addr), d, rst_tbl[i].exp);
    end

    for (int i = 0; i < 6; i++) run_mult(tbl[i].a, tbl[i].b, $sformatf("tbl%0d", i), tbl[i].p);

    for (int i = 0; i < 20; i++) begin
      a = $urandom; b = $urandom;
      if (i < 4) b = b & 32'h0000_00FF;
      run_mult(a, b, $sformatf("rnd%0d", i), 64'(a) * 64'(b));
    end

    // START and OPA write while busy must not disturb the running 7*9.
    wr(3'd0, 32'd7); wr(3'd1, 32'd9); wr(3'd2, 32'd1);
    wr(3'd0, 32'd2);
    @(negedge clk);
    wr(3'd2, 32'd3);
    rd(3'd2, d); check("busy_start_irqen", d, 32'd0);
    wait_done(k, d);
    rd(3'd4, d); check("busy_start_lo", d, 32'd63);
    rd(3'd6, d); check("busy_start_cycles", d, 32'(W));
    rd(3'd0, d); check("busy_opa_reg", d, 32'd2);

    // IRQ_EN together with START; irq follows DONE and drops after clear.
    wr(3'd0, 32'd6); wr(3'd1, 32'd7); wr(3'd2, 32'd3);
    check("irq_while_busy", 32'(irq), 32'd0);
    wait_done(k, d);
    check("irq_lat", 32'(k), 32'(W));
    check("irq_high", 32'(irq), 32'd1);
    wr(3'd3, 32'd2);
    check("irq_cleared", 32'(irq), 32'd0);
    rd(3'd4, d); check("irq_lo", d, 32'd42);
    rd(3'd2, d); check("irq_en_rd", d, 32'd2);

    // DONE clear lands on the completion edge: completion wins.
    wr(3'd2, 32'd1);
    repeat (W - 1) @(negedge clk);
    wr(3'd3, 32'd2);
    rd(3'd3, d); check("clr_vs_done", d, 32'd2);
    wr(3'd3, 32'd2);
    rd(3'd3, d); check("done_clr", d, 32'd0);

    // Read and write together: read returns pre-write data.
    wr(3'd0, 32'hAAAA_5555);
    avs_address = 3'd0; avs_writedata = 32'h1234_0000; avs_write = 1'b1; avs_read = 1'b1;
    @(posedge clk); #1 avs_write = 1'b0; avs_read = 1'b0;
    @(negedge clk);
    check("rw_old", avs_readdata, 32'hAAAA_5555);
    rd(3'd0, d); check("rw_new", d, 32'h1234_0000);

    // Back-to-back reads, one-cycle latency each.
    avs_address = 3'd7; avs_read = 1'b1;
    @(negedge clk);
    check("b2b_v0", 32'(avs_readdatavalid), 32'd1);
    check("b2b_d0", avs_readdata, ID);
    avs_address = 3'd0;
    @(negedge clk);
    check("b2b_v1", 32'(avs_readdatavalid), 32'd1);
    check("b2b_d1", avs_readdata, 32'h1234_0000);
    avs_read = 1'b0;
    @(negedge clk);
    check("b2b_v2", 32'(avs_readdatavalid), 32'd0);

    // Reset at T+10 of 100*100 with IRQ_EN set.
    wr(3'd0, 32'd100); wr(3'd1, 32'd100); wr(3'd2, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_irq", 32'(irq), 32'd0);
    check("mid_rst_rvalid", 32'(avs_readdatavalid), 32'd0);
    rd(3'd3, d); check("mid_rst_status", d, 32'd0);
    rd(3'd4, d); check("mid_rst_lo", d, 32'd0);
    rd(3'd2, d); check("mid_rst_ctrl", d, 32'd0);
    rd(3'd0, d); check("mid_rst_opa", d, 32'd0);
    repeat (W + 4) @(negedge clk);
    rd(3'd3, d); check("mid_rst_no_done", d, 32'd0);
    check("mid_rst_irq_late", 32'(irq), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
